// File: rtl/regfile_write_arbiter_if.sv
// Bundle between writeback/long-latency sources and the register file write port.
interface regfile_write_arbiter_if #(
  parameter int N     = 32,
  parameter int L     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_wa;
  logic [N-1:0]  pipe_wd;
  logic          iss_valid;
  logic [4:0]    iss_wa;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_wa;
  logic [N-1:0]  lu_wd;
  logic          we3;
  logic [4:0]    wa3;
  logic [N-1:0]  wd3;
  logic [L-1:0]  pending;
  logic [CW-1:0] q_count;

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, iss_valid, iss_wa, lu_valid, lu_wa, lu_wd,
    output lu_ready, we3, wa3, wd3, pending, q_count
  );

  modport master (
    output pipe_we, pipe_wa, pipe_wd, iss_valid, iss_wa, lu_valid, lu_wa, lu_wd,
    input  lu_ready, we3, wa3, wd3, pending, q_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges pipe writeback (priority) and FIFO-buffered long-latency results into one registered
// write port, 1-cycle latency; lu_ready drops only when the FIFO is full, pipe is never stalled.
module regfile_write_arbiter #(
  parameter int N     = 32,
  parameter int L     = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_mem_wa [DEPTH];
  logic [N-1:0]  r_mem_wd [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [4:0]    r_wa;
  logic [N-1:0]  r_wd;
  logic [L-1:0]  r_pending;

  logic          w_ready;
  logic          w_pipe_req;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_wa;
  logic [N-1:0]  w_head_wd;
  logic [L-1:0]  w_pending_nxt;

  // Readiness follows current occupancy only, so a full FIFO never accepts even while popping.
  assign w_ready    = !reset && (r_count != CW'(DEPTH));
  assign w_pipe_req = bus.pipe_we && (bus.pipe_wa != 5'd0);
  assign w_push     = bus.lu_valid && w_ready && (bus.lu_wa != 5'd0);
  assign w_pop      = !w_pipe_req && (r_count != '0);
  assign w_head_wa  = r_mem_wa[r_rptr];
  assign w_head_wd  = r_mem_wd[r_rptr];

  always_comb begin
    w_pending_nxt = r_pending;
    for (int r = 1; r < L; r++) begin
      if (w_pop && (w_head_wa == 5'(r))) w_pending_nxt[r] = 1'b0;
      // A new issue to the same register outranks the retiring write.
      if (bus.iss_valid && (bus.iss_wa == 5'(r))) w_pending_nxt[r] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_wa[r_wptr] <= bus.lu_wa;
      r_mem_wd[r_wptr] <= bus.lu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wd      <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pipe_req) begin
        r_we <= 1'b1;
        r_wa <= bus.pipe_wa;
        r_wd <= bus.pipe_wd;
      end else if (w_pop) begin
        r_we <= 1'b1;
        r_wa <= w_head_wa;
        r_wd <= w_head_wd;
      end else begin
        r_we <= 1'b0;
      end
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.lu_ready = w_ready;
  assign bus.we3      = r_we;
  assign bus.wa3      = r_wa;
  assign bus.wd3      = r_wd;
  assign bus.pending  = r_pending;
  assign bus.q_count  = r_count;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Producer side of the register file's single write port (we3/wa3/wd3).
- Merges two result sources into one registered write stream:
  - the in-order pipeline writeback, one write per cycle, always wins;
  - a long-latency unit (mul/div) using a valid/ready handshake, buffered in a small FIFO.
- Keeps a per-register pending scoreboard so the hazard unit can stall readers of registers whose long-latency result is not yet written.
- Sits between the writeback stage / long-latency unit and the register file.

Parameters:
- N, 32, data width; must match the register file width.
- L, 32, number of architectural registers; width of the pending vector.
- DEPTH, 4, long-latency FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request this cycle.
- pipe_wa  in  5  pipeline destination register.
- pipe_wd  in  N  pipeline write data.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_wa  in  5  destination register of the issued long-latency op.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_wa  in  5  long-latency result destination.
- lu_wd  in  N  long-latency result data.
- we3  out  1  register file write enable, registered.
- wa3  out  5  register file write address, registered.
- wd3  out  N  register file write data, registered.
- pending  out  L  bit r set while register r awaits a long-latency write.
- q_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, high), effective at the next posedge:
  - we3=0, wa3=0, wd3=0;
  - FIFO empty, q_count=0;
  - pending all zero.
- lu_ready is 0 while reset is high.
- Reset mid-operation discards all queued results and pending bits.
- Handshake: a transfer occurs when lu_valid && lu_ready at a posedge.
  - lu_ready = !reset && (q_count != DEPTH); it depends only on current occupancy.
  - A same-cycle pop does not free a slot for a same-cycle push when the FIFO is full.
- Register 0 is never written:
  - a pipe_we with pipe_wa=0 is treated as no request;
  - an accepted lu transfer with lu_wa=0 is consumed (handshake completes) but is not enqueued.
- Output selection each cycle, registered into we3/wa3/wd3 at the posedge, so outputs are valid 1 cycle after the input:
  - If pipe_we && pipe_wa!=0: output the pipe write. The FIFO does not pop.
  - Else if FIFO not empty: pop the head and output it.
  - Else: we3=0. wa3 and wd3 hold their previous values.
- Outputs change only on posedge, so they are stable for the register file's negedge write.
- FIFO:
  - circular buffer with read/write pointers that wrap modulo DEPTH;
  - push and pop in the same cycle leave q_count unchanged;
  - strict order is preserved, with no reordering against other FIFO entries.
- Scoreboard, per register r, at each posedge:
  - set when iss_valid && iss_wa==r && r!=0;
  - clear when a FIFO pop writes register r;
  - if set and clear hit the same register in the same cycle, set wins (a newer op is outstanding);
  - pending[0] is always 0;
  - pipe writes never touch pending.
- No back-pressure on the pipe path. A continuous pipe stream starves the FIFO by design; the hazard unit bounds this.
- Simultaneous pipe write and FIFO head targeting the same register: the pipe write goes first, the FIFO entry follows later. Last writer is the FIFO entry; the pipeline guarantees correctness through pending stalls.

Test Plan:
- Reset: hold reset 2 cycles with lu_valid=1 -> lu_ready=0, we3=0, pending=0, q_count=0; release -> lu_ready=1 next cycle.
- Pipe only: pipe_we=1, wa=5, wd=0x1234 -> next posedge we3=1, wa3=5, wd3=0x1234; then pipe_wa=0 with we=1 -> we3=0.
- FIFO fill/drain with DEPTH=4:
  - hold pipe_we=1 with nonzero wa and push lu results wa=8..11 -> q_count=4, lu_ready=0, fifth result stalls;
  - drop pipe_we -> results written in order 8,9,10,11 on consecutive cycles, then we3=0.
- Scoreboard: iss_valid wa=9 -> pending[9]=1; lu result wa=9 pops -> pending[9]=0 the same posedge as we3=1, wa3=9.
- Set-wins: pending[9]=1, FIFO head wa=9 pops in the same cycle as iss_valid wa=9 -> write emitted, pending[9] stays 1.
- Wrap and zero-drop:
  - push and pop 10 results through DEPTH=4 -> data and order preserved across pointer wrap;
  - lu result with wa=0 is accepted but never appears on we3.
